// File: rtl/mips_pkg.sv
// Shared MIPS core widths and the layout of the decoder's control bundle.
package mips_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTRL_W = 10;

  // Bit positions of the control fields inside the packed bundle
  localparam int unsigned CTRL_REGWRITE = 9;
  localparam int unsigned CTRL_MEMREAD  = 8;
  localparam int unsigned CTRL_MEMWRITE = 7;
  localparam int unsigned CTRL_MEMTOREG = 6;
  localparam int unsigned CTRL_BRANCH   = 5;
  localparam int unsigned CTRL_ALUSRC   = 4;
  localparam int unsigned CTRL_REGDST   = 3;
  localparam int unsigned CTRL_ALUOP_HI = 2;
  localparam int unsigned CTRL_ALUOP_LO = 0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/id_ex_if.sv
// ID-side payload and hazard controls in, EX-side registered payload out.
interface id_ex_if;
  import mips_pkg::*;

  logic              stall;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_pc4;
  logic [DATA_W-1:0] id_readData1;
  logic [DATA_W-1:0] id_readData2;
  logic [DATA_W-1:0] id_signExtend;
  logic [REG_W-1:0]  id_rs;
  logic [REG_W-1:0]  id_rt;
  logic [REG_W-1:0]  id_rd;
  ctrl_t             id_ctrl;

  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_readData1;
  logic [DATA_W-1:0] ex_readData2;
  logic [DATA_W-1:0] ex_signExtend;
  logic [DATA_W-1:0] ex_branchTarget;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  ctrl_t             ex_ctrl;

  modport master (
    output stall, flush, id_valid, id_pc4, id_readData1, id_readData2, id_signExtend,
           id_rs, id_rt, id_rd, id_ctrl,
    input  ex_valid, ex_pc4, ex_readData1, ex_readData2, ex_signExtend, ex_branchTarget,
           ex_rs, ex_rt, ex_rd, ex_ctrl
  );

  modport slave (
    input  stall, flush, id_valid, id_pc4, id_readData1, id_readData2, id_signExtend,
           id_rs, id_rt, id_rd, id_ctrl,
    output ex_valid, ex_pc4, ex_readData1, ex_readData2, ex_signExtend, ex_branchTarget,
           ex_rs, ex_rt, ex_rd, ex_ctrl
  );
endinterface

// File: rtl/branch_target_adder.sv
// Branch target in ID: pc4 + (imm << 2), wrapping modulo 2^DATA_W.
module branch_target_adder #(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] pc4,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] target_c
);
  assign target_c = pc4 + DATA_W'(imm << 2);
endmodule

// File: rtl/id_ex_register.sv
// ID->EX pipeline register with stall hold and flush bubble insertion.
// Define PIPE_PERF_EN to add stall/flush event counters.
module id_ex_register
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  id_ex_if.slave      bus
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  logic [DATA_W-1:0] branch_target_c;

  branch_target_adder #(.DATA_W(DATA_W)) u_bta (
    .pc4      (bus.id_pc4),
    .imm      (bus.id_signExtend),
    .target_c (branch_target_c)
  );

  // Priority: flush > stall > load; a bubble carries no control bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid        <= 1'b0;
      bus.ex_pc4          <= '0;
      bus.ex_readData1    <= '0;
      bus.ex_readData2    <= '0;
      bus.ex_signExtend   <= '0;
      bus.ex_branchTarget <= '0;
      bus.ex_rs           <= '0;
      bus.ex_rt           <= '0;
      bus.ex_rd           <= '0;
      bus.ex_ctrl         <= CTRL_NOP;
    end else if (bus.flush) begin
      bus.ex_valid        <= 1'b0;
      bus.ex_pc4          <= '0;
      bus.ex_readData1    <= '0;
      bus.ex_readData2    <= '0;
      bus.ex_signExtend   <= '0;
      bus.ex_branchTarget <= '0;
      bus.ex_rs           <= '0;
      bus.ex_rt           <= '0;
      bus.ex_rd           <= '0;
      bus.ex_ctrl         <= CTRL_NOP;
    end else if (!bus.stall) begin
      bus.ex_valid        <= bus.id_valid;
      bus.ex_pc4          <= bus.id_pc4;
      bus.ex_readData1    <= bus.id_readData1;
      bus.ex_readData2    <= bus.id_readData2;
      bus.ex_signExtend   <= bus.id_signExtend;
      bus.ex_branchTarget <= branch_target_c;
      bus.ex_rs           <= bus.id_rs;
      bus.ex_rt           <= bus.id_rt;
      bus.ex_rd           <= bus.id_rd;
      bus.ex_ctrl         <= bus.id_valid ? bus.id_ctrl : CTRL_NOP;
    end
  end

`ifdef PIPE_PERF_EN
  // Event counters wrap naturally; a flush edge never counts as a stall
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else if (bus.flush) begin
      perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end else if (bus.stall) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: per-cycle model compare plus literal checks.
module tb_id_ex_register;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  id_ex_if bus();
`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  id_ex_register dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef PIPE_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  int tests = 0;
  int errs  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the EX slot should hold, derived from the pipeline rules
  logic        m_valid;
  logic [31:0] m_pc4, m_rd1, m_rd2, m_se, m_bt;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [9:0]  m_ctrl;
  logic [31:0] m_stalls, m_flushes;

  task automatic model_bubble();
    m_valid = 1'b0; m_pc4 = '0; m_rd1 = '0; m_rd2 = '0; m_se = '0; m_bt = '0;
    m_rs = '0; m_rt = '0; m_rd = '0; m_ctrl = '0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_bubble();
      m_stalls = '0;
      m_flushes = '0;
    end else if (bus.flush) begin
      model_bubble();
      m_flushes = m_flushes + 32'd1;
    end else if (bus.stall) begin
      m_stalls = m_stalls + 32'd1;
    end else begin
      m_valid = bus.id_valid;
      m_pc4   = bus.id_pc4;
      m_rd1   = bus.id_readData1;
      m_rd2   = bus.id_readData2;
      m_se    = bus.id_signExtend;
      m_bt    = 32'((64'(bus.id_pc4) + 64'(bus.id_signExtend) * 64'd4) % 64'h1_0000_0000);
      m_rs    = bus.id_rs;
      m_rt    = bus.id_rt;
      m_rd    = bus.id_rd;
      m_ctrl  = bus.id_valid ? 10'(bus.id_ctrl) : 10'd0;
    end
  end

  always @(negedge clk) begin
    chk("cyc_valid", 32'(bus.ex_valid), 32'(m_valid));
    chk("cyc_pc4",   bus.ex_pc4, m_pc4);
    chk("cyc_rd1",   bus.ex_readData1, m_rd1);
    chk("cyc_rd2",   bus.ex_readData2, m_rd2);
    chk("cyc_se",    bus.ex_signExtend, m_se);
    chk("cyc_bt",    bus.ex_branchTarget, m_bt);
    chk("cyc_rs",    32'(bus.ex_rs), 32'(m_rs));
    chk("cyc_rt",    32'(bus.ex_rt), 32'(m_rt));
    chk("cyc_rd",    32'(bus.ex_rd), 32'(m_rd));
    chk("cyc_ctrl",  32'(bus.ex_ctrl), 32'(m_ctrl));
`ifdef PIPE_PERF_EN
    chk("cyc_pstall", perf_stall_cnt, m_stalls);
    chk("cyc_pflush", perf_flush_cnt, m_flushes);
`endif
  end

  task automatic drive(input logic st, input logic fl, input logic v,
                       input logic [31:0] pc4, input logic [31:0] rd1, input logic [31:0] rd2,
                       input logic [31:0] se, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [9:0] ctrl);
    bus.stall = st; bus.flush = fl; bus.id_valid = v;
    bus.id_pc4 = pc4; bus.id_readData1 = rd1; bus.id_readData2 = rd2;
    bus.id_signExtend = se; bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
    bus.id_ctrl = ctrl_t'(ctrl);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    drive(0, 0, 0, '0, '0, '0, '0, '0, '0, '0, '0);
    #2;
    chk("rst_valid", 32'(bus.ex_valid), 32'd0);
    chk("rst_ctrl", 32'(bus.ex_ctrl), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Load with negative offset
    drive(0, 0, 1, 32'h0040_0004, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFE,
          5'd1, 5'd2, 5'd3, 10'h2A5);
    tick();
    chk("load_valid", 32'(bus.ex_valid), 32'd1);
    chk("load_bt", bus.ex_branchTarget, 32'h003F_FFFC);
    chk("load_rd1", bus.ex_readData1, 32'h1111_1111);
    chk("load_se", bus.ex_signExtend, 32'hFFFF_FFFE);
    chk("load_rt", 32'(bus.ex_rt), 32'd2);
    chk("load_ctrl", 32'(bus.ex_ctrl), 32'h2A5);

    // Asynchronous reset mid-cycle with a valid entry held
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.ex_valid), 32'd0);
    chk("arst_bt", bus.ex_branchTarget, 32'd0);
    chk("arst_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("arst_pc4", bus.ex_pc4, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;

    // Branch target wraps past 2^32
    drive(0, 0, 1, 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0000_0002, 5'd4, 5'd5, 5'd6, 10'h021);
    tick();
    chk("wrap_bt", bus.ex_branchTarget, 32'h0000_0004);

    // Stall holds entry A for three cycles despite changing ID inputs
    drive(0, 0, 1, 32'h0000_0100, 32'hAAAA_0001, 32'hAAAA_0002, 32'h0000_0010,
          5'd7, 5'd8, 5'd9, 10'h055);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 1, 32'h0000_0200 + 32'(i), 32'hBBBB_0000, 32'hCCCC_0000, 32'h0000_0020,
            5'd10, 5'd11, 5'd12, 10'h1C3);
      tick();
      chk("stall_pc4", bus.ex_pc4, 32'h0000_0100);
      chk("stall_bt", bus.ex_branchTarget, 32'h0000_0140);
      chk("stall_ctrl", 32'(bus.ex_ctrl), 32'h055);
    end
    drive(0, 0, 1, 32'h0000_0300, 32'hDDDD_0000, 32'hEEEE_0000, 32'h0000_0001,
          5'd13, 5'd14, 5'd15, 10'h0F0);
    tick();
    chk("unstall_pc4", bus.ex_pc4, 32'h0000_0300);
    chk("unstall_bt", bus.ex_branchTarget, 32'h0000_0304);

    // Flush wins over stall on the same edge
    drive(1, 1, 1, 32'h0000_0400, 32'h1, 32'h2, 32'h3, 5'd16, 5'd17, 5'd18, 10'h3FF);
    tick();
    chk("flush_valid", 32'(bus.ex_valid), 32'd0);
    chk("flush_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("flush_pc4", bus.ex_pc4, 32'd0);
`ifdef PIPE_PERF_EN
    chk("flush_pflush", perf_flush_cnt, 32'd1);
    chk("flush_pstall", perf_stall_cnt, 32'd3);
`endif

    // Invalid load captures data but no control
    drive(0, 0, 0, 32'h0000_0500, 32'h5, 32'h6, 32'h0, 5'd19, 5'd20, 5'd21, 10'h3FF);
    tick();
    chk("inv_valid", 32'(bus.ex_valid), 32'd0);
    chk("inv_ctrl", 32'(bus.ex_ctrl), 32'd0);
    chk("inv_pc4", bus.ex_pc4, 32'h0000_0500);

    // Valid load followed by a plain flush
    drive(0, 0, 1, 32'h0000_0600, 32'h7, 32'h8, 32'hFFFF_FFFF, 5'd22, 5'd23, 5'd24, 10'h200);
    tick();
    chk("load2_bt", bus.ex_branchTarget, 32'h0000_05FC);
    drive(0, 1, 1, 32'h0000_0700, 32'h9, 32'hA, 32'h0, 5'd25, 5'd26, 5'd27, 10'h100);
    tick();
    chk("flush2_valid", 32'(bus.ex_valid), 32'd0);
`ifdef PIPE_PERF_EN
    chk("flush2_pflush", perf_flush_cnt, 32'd2);
`endif

    drive(0, 0, 0, '0, '0, '0, '0, '0, '0, '0, '0);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
